cavlc_level_sequencer: RTL and testbench

Sequences level decoding for one CAVLC residual block. It emits the trailing-ones levels, then for each remaining coefficient collects level_prefix and level_suffix from the bitstream parser, forms levelCode, triggers the level processing unit, and adapts suffixLength. It sits between the coeff_token stage and the level processing unit in the CAVLC decode path.

---
 rtl/cavlc_pkg.sv | 15 +
 rtl/cavlc_level_code.sv | 38 +++
 rtl/cavlc_level_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_cavlc_level_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_pkg.sv
// Shared CAVLC level-decode types and constants.
package cavlc_pkg;
  localparam int MAX_SUFFIX_LEN = 6;
  localparam int LC_W           = 14;
  localparam int LEVEL_W        = 13;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    PREFIX,
    SUFFIX,
    ISSUE,
    DONE
  } lvl_seq_state_t;
endpackage

// File: rtl/cavlc_level_code.sv
// Combinational levelCode and levelSuffixSize from level_prefix, level_suffix
// and the current suffixLength. Result wraps modulo 2^CODE_W.
module cavlc_level_code import cavlc_pkg::*; #(
  parameter int CODE_W = 14
) (
  input  logic [4:0]         prefix,
  input  logic [LEVEL_W-1:0] suffix,
  input  logic [2:0]         sl,
  input  logic               first_lvl,
  input  logic [1:0]         trailing_ones,
  output logic [CODE_W-1:0]  level_code,
  output logic [3:0]         suf_size
);

  logic [3:0] pfx_min;

  always_comb begin
    pfx_min = (prefix >= 5'd15) ? 4'd15 : prefix[3:0];

    if (prefix == 5'd14 && sl == 3'd0)
      suf_size = 4'd4;
    else if (prefix >= 5'd15)
      suf_size = 4'(prefix - 5'd3);
    else
      suf_size = {1'b0, sl};

    level_code = CODE_W'(pfx_min) << sl;
    level_code = level_code + CODE_W'(suffix);
    if (prefix >= 5'd15 && sl == 3'd0)
      level_code = level_code + CODE_W'(15);
    // Escape codes: the 4096 offset cancels part of the 1<<(prefix-3) term.
    if (prefix >= 5'd16)
      level_code = level_code + (CODE_W'(1) << (prefix - 5'd3)) - CODE_W'(4096);
    if (first_lvl && trailing_ones != 2'd3)
      level_code = level_code + CODE_W'(2);
  end

endmodule

// File: rtl/cavlc_level_sequencer.sv
// CAVLC level sequencer: trailing ones, then prefix/suffix collection per level.
// Define CAVLC_LVL_ESC16_EN to accept level_prefix 16 (escape); otherwise it aborts with LvlErr.
module cavlc_level_sequencer import cavlc_pkg::*; #(
  parameter int MAX_COEFF = 16,
  parameter int LC_W      = 14
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               BlkStart,
  input  logic [4:0]         TotalCoeff,
  input  logic [1:0]         TrailingOnes,
  input  logic [2:0]         T1Signs,
  output logic               BlkBusy,
  input  logic               PfxValid,
  output logic               PfxReady,
  input  logic [4:0]         LevelPrefix,
  output logic               SufReq,
  output logic [3:0]         SufLen,
  input  logic               SufValid,
  input  logic [LEVEL_W-1:0] LevelSuffix,
  output logic               LPUTrig,
  output logic [2:0]         SuffixLength,
  output logic [LC_W-1:0]    CodeNum,
  output logic               T1Wr,
  output logic               T1Neg,
  output logic [3:0]         LevelIdx,
  output logic               BlkDone,
  output logic               LvlErr
);

`ifdef CAVLC_LVL_ESC16_EN
  localparam logic [4:0] MAX_PFX = 5'd16;
`else
  localparam logic [4:0] MAX_PFX = 5'd15;
`endif

  lvl_seq_state_t     state;
  logic [4:0]         tc;
  logic [4:0]         idx;
  logic [4:0]         prefix_reg;
  logic [1:0]         t1_cnt;
  logic [2:0]         t1_signs;
  logic [2:0]         sl;
  logic               first_lvl;

  logic [4:0]         tc_clamp;
  logic [4:0]         pfx_sel;
  logic [LEVEL_W-1:0] suf_sel;
  logic [LC_W-1:0]    level_code;
  logic [3:0]         suf_size;
  logic [2:0]         sl_base;
  logic [2:0]         sl_next;

  assign PfxReady = (state == PREFIX);
  assign SufReq   = (state == SUFFIX);

  assign tc_clamp = (TotalCoeff > 5'(MAX_COEFF)) ? 5'(MAX_COEFF) : TotalCoeff;

  // The code is evaluated on the edge that enters ISSUE, so feed it the live inputs.
  assign pfx_sel = (state == PREFIX) ? LevelPrefix : prefix_reg;
  assign suf_sel = (state == SUFFIX) ? LevelSuffix : '0;

  cavlc_level_code #(.CODE_W(LC_W)) u_code (
    .prefix        (pfx_sel),
    .suffix        (suf_sel),
    .sl            (sl),
    .first_lvl     (first_lvl),
    .trailing_ones (t1_cnt),
    .level_code    (level_code),
    .suf_size      (suf_size)
  );

  // Adaptation threshold uses the suffixLength after the 0->1 promotion.
  always_comb begin
    sl_base = (sl == 3'd0) ? 3'd1 : sl;
    if (({1'b0, CodeNum[LC_W-1:1]} + LC_W'(1)) > (LC_W'(3) << (sl_base - 3'd1))
        && sl_base < 3'(MAX_SUFFIX_LEN))
      sl_next = sl_base + 3'd1;
    else
      sl_next = sl_base;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      tc           <= '0;
      idx          <= '0;
      prefix_reg   <= '0;
      t1_cnt       <= '0;
      t1_signs     <= '0;
      sl           <= '0;
      first_lvl    <= 1'b0;
      BlkBusy      <= 1'b0;
      SufLen       <= '0;
      LPUTrig      <= 1'b0;
      SuffixLength <= '0;
      CodeNum      <= '0;
      T1Wr         <= 1'b0;
      T1Neg        <= 1'b0;
      LevelIdx     <= '0;
      BlkDone      <= 1'b0;
      LvlErr       <= 1'b0;
    end else begin
      T1Wr    <= 1'b0;
      LPUTrig <= 1'b0;
      BlkDone <= 1'b0;
      LvlErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (BlkStart) begin
            tc        <= tc_clamp;
            t1_cnt    <= TrailingOnes;
            t1_signs  <= T1Signs;
            first_lvl <= 1'b1;
            BlkBusy   <= 1'b1;
            sl        <= (TotalCoeff > 5'd10 && TrailingOnes != 2'd3) ? 3'd1 : 3'd0;
            if (tc_clamp == 5'd0) begin
              idx     <= '0;
              BlkDone <= 1'b1;
              state   <= DONE;
            end else if (TrailingOnes != 2'd0) begin
              T1Wr     <= 1'b1;
              T1Neg    <= T1Signs[2];
              LevelIdx <= '0;
              idx      <= 5'd1;
              state    <= T1;
            end else begin
              idx   <= '0;
              state <= PREFIX;
            end
          end
        end
        T1: begin
          if (idx < {3'b000, t1_cnt}) begin
            T1Wr     <= 1'b1;
            T1Neg    <= t1_signs[2'd2 - idx[1:0]];
            LevelIdx <= idx[3:0];
            idx      <= idx + 5'd1;
          end else if (idx < tc) begin
            state <= PREFIX;
          end else begin
            BlkDone <= 1'b1;
            state   <= DONE;
          end
        end
        PREFIX: begin
          if (PfxValid) begin
            prefix_reg <= LevelPrefix;
            if (LevelPrefix > MAX_PFX) begin
              LvlErr  <= 1'b1;
              BlkBusy <= 1'b0;
              state   <= IDLE;
            end else if (suf_size != 4'd0) begin
              SufLen <= suf_size;
              state  <= SUFFIX;
            end else begin
              LPUTrig      <= 1'b1;
              CodeNum      <= level_code;
              SuffixLength <= sl;
              LevelIdx     <= idx[3:0];
              state        <= ISSUE;
            end
          end
        end
        SUFFIX: begin
          if (SufValid) begin
            LPUTrig      <= 1'b1;
            CodeNum      <= level_code;
            SuffixLength <= sl;
            LevelIdx     <= idx[3:0];
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          first_lvl <= 1'b0;
          idx       <= idx + 5'd1;
          sl        <= sl_next;
          if ((idx + 5'd1) < tc) begin
            state <= PREFIX;
          end else begin
            BlkDone <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          BlkBusy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_level_sequencer.sv
// Directed bench for cavlc_level_sequencer with an event scoreboard.
// Honors CAVLC_LVL_ESC16_EN for the prefix-16 step.
module tb_cavlc_level_sequencer;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        BlkStart = 1'b0;
  logic [4:0]  TotalCoeff = '0;
  logic [1:0]  TrailingOnes = '0;
  logic [2:0]  T1Signs = '0;
  logic        BlkBusy;
  logic        PfxValid = 1'b0;
  logic        PfxReady;
  logic [4:0]  LevelPrefix = '0;
  logic        SufReq;
  logic [3:0]  SufLen;
  logic        SufValid = 1'b0;
  logic [12:0] LevelSuffix = '0;
  logic        LPUTrig;
  logic [2:0]  SuffixLength;
  logic [13:0] CodeNum;
  logic        T1Wr;
  logic        T1Neg;
  logic [3:0]  LevelIdx;
  logic        BlkDone;
  logic        LvlErr;

  cavlc_level_sequencer dut (
    .Clk(Clk), .nReset(nReset), .BlkStart(BlkStart), .TotalCoeff(TotalCoeff),
    .TrailingOnes(TrailingOnes), .T1Signs(T1Signs), .BlkBusy(BlkBusy),
    .PfxValid(PfxValid), .PfxReady(PfxReady), .LevelPrefix(LevelPrefix),
    .SufReq(SufReq), .SufLen(SufLen), .SufValid(SufValid), .LevelSuffix(LevelSuffix),
    .LPUTrig(LPUTrig), .SuffixLength(SuffixLength), .CodeNum(CodeNum),
    .T1Wr(T1Wr), .T1Neg(T1Neg), .LevelIdx(LevelIdx), .BlkDone(BlkDone), .LvlErr(LvlErr)
  );

  always #5 Clk = ~Clk;

  // kind: 1 = trailing-one write, 2 = LPU trigger, 3 = block done, 4 = level error
  typedef struct {
    int kind;
    int idx;
    int neg;
    int code;
    int sl;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int idx, input int neg, input int code, input int sl);
    ev_t e;
    e.kind = kind; e.idx = idx; e.neg = neg; e.code = code; e.sl = sl;
    exp_q.push_back(e);
  endtask

  task automatic observe();
    int  k;
    ev_t e;
    k = T1Wr ? 1 : LPUTrig ? 2 : BlkDone ? 3 : LvlErr ? 4 : 0;
    if (k != 0) begin
      $display("txn kind=%0d idx=%0d neg=%0d code=%0d sl=%0d", k, LevelIdx, T1Neg, CodeNum, SuffixLength);
      e.kind = 0; e.idx = 0; e.neg = 0; e.code = 0; e.sl = 0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      if (k == e.kind) begin
        case (k)
          1: begin
            chk("t1_idx", int'(LevelIdx), e.idx);
            chk("t1_neg", int'(T1Neg), e.neg);
          end
          2: begin
            chk("lpu_idx", int'(LevelIdx), e.idx);
            chk("lpu_code", int'(CodeNum), e.code);
            chk("lpu_sl", int'(SuffixLength), e.sl);
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic step();
    @(negedge Clk);
    observe();
  endtask

  task automatic start(input int tc, input int t1, input int signs);
    BlkStart = 1'b1;
    TotalCoeff = 5'(tc);
    TrailingOnes = 2'(t1);
    T1Signs = 3'(signs);
    step();
    BlkStart = 1'b0;
  endtask

  task automatic send_prefix(input int p);
    int n = 0;
    while (PfxReady !== 1'b1 && n < 50) begin step(); n++; end
    chk("pfx_ready", int'(PfxReady), 1);
    PfxValid = 1'b1;
    LevelPrefix = 5'(p);
    step();
    PfxValid = 1'b0;
  endtask

  task automatic send_suffix(input int len, input int s);
    int n = 0;
    while (SufReq !== 1'b1 && n < 50) begin step(); n++; end
    chk("suf_req", int'(SufReq), 1);
    chk("suf_len", int'(SufLen), len);
    SufValid = 1'b1;
    LevelSuffix = 13'(s);
    step();
    SufValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BlkBusy === 1'b1 && n < 100) begin step(); n++; end
    chk("busy_drop", int'(BlkBusy), 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_zero_outs();
    chk("rst_busy", int'(BlkBusy), 0);
    chk("rst_pfxready", int'(PfxReady), 0);
    chk("rst_sufreq", int'(SufReq), 0);
    chk("rst_suflen", int'(SufLen), 0);
    chk("rst_lputrig", int'(LPUTrig), 0);
    chk("rst_suffixlength", int'(SuffixLength), 0);
    chk("rst_codenum", int'(CodeNum), 0);
    chk("rst_t1wr", int'(T1Wr), 0);
    chk("rst_t1neg", int'(T1Neg), 0);
    chk("rst_levelidx", int'(LevelIdx), 0);
    chk("rst_blkdone", int'(BlkDone), 0);
    chk("rst_lvlerr", int'(LvlErr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (2) @(negedge Clk);
    chk_zero_outs();
    nReset = 1'b1;
    step();

    // Three trailing ones only; first write lands the cycle after BlkStart.
    push(1, 0, 1, 0, 0); push(1, 1, 0, 0, 0); push(1, 2, 1, 0, 0); push(3, 0, 0, 0, 0);
    start(3, 3, 3'b101);
    chk("t1_first", int'(T1Wr), 1);
    chk("busy_after_start", int'(BlkBusy), 1);
    wait_idle();

    // Two levels, sl starts at 0; first level carries the +2 bias.
    push(2, 0, 0, 3, 0);
    start(2, 0, 0);
    send_prefix(1);
    BlkStart = 1'b1;
    TotalCoeff = 5'd0;
    step();
    BlkStart = 1'b0;
    push(2, 1, 0, 0, 1); push(3, 0, 0, 0, 0);
    send_prefix(0);
    send_suffix(1, 0);
    step();
    chk("done_after_lpu", int'(BlkDone), 1);
    wait_idle();

    // TotalCoeff > 10: sl starts at 1 and grows to 2; reset lands in SUFFIX.
    push(2, 0, 0, 9, 1);
    start(11, 0, 0);
    send_prefix(3);
    send_suffix(1, 1);
    push(2, 1, 0, 2, 2);
    send_prefix(0);
    send_suffix(2, 2);
    send_prefix(0);
    n = 0;
    while (SufReq !== 1'b1 && n < 50) begin step(); n++; end
    chk("sufreq_before_reset", int'(SufReq), 1);
    nReset = 1'b0;
    #1;
    chk_zero_outs();
    @(negedge Clk);
    nReset = 1'b1;
    repeat (3) step();
    chk("no_done_after_reset", exp_q.size(), 0);
    chk("idle_after_reset", int'(BlkBusy), 0);

    // Fresh block after reset: prefix 14 with sl=0 takes a 4-bit suffix.
    push(1, 0, 0, 0, 0); push(1, 1, 1, 0, 0); push(1, 2, 0, 0, 0);
    push(2, 3, 0, 19, 0); push(3, 0, 0, 0, 0);
    start(4, 3, 3'b010);
    send_prefix(14);
    send_suffix(4, 5);
    wait_idle();

    // Prefix 16 with sl=0.
    push(1, 0, 1, 0, 0); push(1, 1, 1, 0, 0); push(1, 2, 1, 0, 0);
`ifdef CAVLC_LVL_ESC16_EN
    // 15 + 0 + 15 + (1<<13) - 4096
    push(2, 3, 0, 4126, 0); push(3, 0, 0, 0, 0);
    start(4, 3, 3'b111);
    send_prefix(16);
    send_suffix(13, 0);
    wait_idle();
`else
    push(4, 0, 0, 0, 0);
    start(4, 3, 3'b111);
    send_prefix(16);
    chk("esc16_abort_busy", int'(BlkBusy), 0);
    chk("esc16_abort_pfxready", int'(PfxReady), 0);
    repeat (3) step();
    chk("esc16_queue", exp_q.size(), 0);
`endif

    // Prefix 17 always aborts.
    push(4, 0, 0, 0, 0);
    start(1, 0, 0);
    send_prefix(17);
    chk("pfx17_abort_busy", int'(BlkBusy), 0);
    repeat (3) step();
    chk("pfx17_queue", exp_q.size(), 0);

    // Empty block goes straight to done.
    push(3, 0, 0, 0, 0);
    start(0, 0, 0);
    chk("tc0_done", int'(BlkDone), 1);
    wait_idle();

    // TotalCoeff 31 clamps to 16: 3 trailing ones plus 13 zero levels.
    push(1, 0, 0, 0, 0); push(1, 1, 0, 0, 0); push(1, 2, 0, 0, 0);
    push(2, 3, 0, 0, 0);
    for (int i = 4; i < 16; i++) push(2, i, 0, 0, 1);
    push(3, 0, 0, 0, 0);
    start(31, 3, 3'b000);
    send_prefix(0);
    for (int i = 4; i < 16; i++) begin
      send_prefix(0);
      send_suffix(1, 0);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
